// File: rtl/ca_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// ca_cmd_decoder_if
//
// Bundles the DDR5 CA/CS link and the decoded command outputs of
// ca_cmd_decoder.
//
//   CS_n        chip select, active low; low marks UI1 of a packet
//   CA[13:0]    command/address bus
//   cmd_valid   one-cycle pulse, legal command decoded
//   cmd_type    8=ACT, 5=WRA, 12=RDA, 0=none
//   bg, ba      decoded bank group / bank
//   row, col    decoded row (ACT) / column (WRA, RDA)
//   bank_open   open flag per bank, index {bg,ba}
//   err_frame   one-cycle pulse, CS_n low again during UI2
//   err_illegal one-cycle pulse, undecodable packet
//   err_bank    one-cycle pulse, bank-state violation
//
// Modports:
//   master - controller / stimulus side: drives CS_n and CA, observes results
//   slave  - decoder side: samples CS_n and CA, drives results
// ---------------------------------------------------------------------------
interface ca_cmd_decoder_if;
  logic        CS_n;
  logic [13:0] CA;
  logic        cmd_valid;
  logic [3:0]  cmd_type;
  logic [2:0]  bg;
  logic        ba;
  logic [15:0] row;
  logic [9:0]  col;
  logic [15:0] bank_open;
  logic        err_frame;
  logic        err_illegal;
  logic        err_bank;

  modport master (
    output CS_n,
    output CA,
    input  cmd_valid,
    input  cmd_type,
    input  bg,
    input  ba,
    input  row,
    input  col,
    input  bank_open,
    input  err_frame,
    input  err_illegal,
    input  err_bank
  );

  modport slave (
    input  CS_n,
    input  CA,
    output cmd_valid,
    output cmd_type,
    output bg,
    output ba,
    output row,
    output col,
    output bank_open,
    output err_frame,
    output err_illegal,
    output err_bank
  );
endinterface

// File: rtl/ca_cmd_decoder.sv
// ---------------------------------------------------------------------------
// ca_cmd_decoder
//
// Device-side receiver for the DDR5 CA bus. Frames two-UI command packets
// (UI1 marked by CS_n low, UI2 by CS_n high on the following edge), decodes
// ACT, WRA and RDA into bank group / bank / row / column, and tracks the
// open/closed state of all 16 banks. Malformed packets and bank-state
// violations are reported as one-cycle error pulses.
//
// Ports:
//   clk    sampling clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    ca_cmd_decoder_if.slave (CS_n/CA in, decoded results out)
//
// Build option:
//   CA_RSVD_CHECK_EN  when defined, packets that pass the opcode check are
//                     additionally required to carry 0 in every fixed-zero
//                     field and 1 in every VALID bit, else err_illegal.
//                     When undefined, only opcode bits are checked.
// ---------------------------------------------------------------------------
module ca_cmd_decoder (
  input  logic             clk,
  input  logic             rst_n,
  ca_cmd_decoder_if.slave  bus
);

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_UI2  = 1'b1;

  // Command type codes as reported on cmd_type
  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ACT  = 4'd8;
  localparam logic [3:0] CMD_WRA  = 4'd5;
  localparam logic [3:0] CMD_RDA  = 4'd12;

  localparam int NUM_BANKS = 16;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [13:0] ui1_q;
  logic [13:0] ui1_next;

  logic        cmd_valid_q;
  logic [3:0]  cmd_type_q;
  logic [2:0]  bg_q;
  logic        ba_q;
  logic [15:0] row_q;
  logic [9:0]  col_q;
  logic [15:0] bank_open_q;
  logic        err_frame_q;
  logic        err_illegal_q;
  logic        err_bank_q;

  logic        cmd_valid_next;
  logic [3:0]  cmd_type_next;
  logic [2:0]  bg_next;
  logic        ba_next;
  logic [15:0] row_next;
  logic [9:0]  col_next;
  logic [15:0] bank_open_next;
  logic        err_frame_next;
  logic        err_illegal_next;
  logic        err_bank_next;

  // ------------------------------------------------------------------
  // Packet view: u = latched UI1, v = UI2 currently on the bus
  // ------------------------------------------------------------------
  logic [13:0] u;
  logic [13:0] v;
  assign u = ui1_q;
  assign v = bus.CA;

  // Framing events
  logic decode_fire;  // UI2 sampled this edge
  logic frame_err;    // CS_n low again while waiting for UI2
  assign decode_fire = (state == ST_UI2) &&  bus.CS_n;
  assign frame_err   = (state == ST_UI2) && !bus.CS_n;

  // Opcode match
  logic op_act;
  logic op_wra;
  logic op_rda;
  assign op_act = (u[1:0] == 2'b00);
  assign op_wra = (u[1:0] == 2'b01) && (u[5:2] == 4'b0011);
  assign op_rda = (u[1:0] == 2'b01) && (u[5:2] == 4'b0111);

  // Reserved-field / VALID-bit qualification per command
  logic rsvd_ok_act;
  logic rsvd_ok_wra;
  logic rsvd_ok_rda;

`ifdef CA_RSVD_CHECK_EN
  logic ui1_zero_ok;
  assign ui1_zero_ok = (u[13:11] == 3'b000) && !u[7];
  assign rsvd_ok_act = ui1_zero_ok && (v[13:12] == 2'b00);
  // WRA: fixed zeros v13, v11, v10, v8; VALID bits v0, v9, v12
  assign rsvd_ok_wra = ui1_zero_ok &&
                       !v[13] && !v[11] && !v[10] && !v[8] &&
                       v[0] && v[9] && v[12];
  // RDA: fixed zeros v13, v10, v8; VALID bits v9, v11, v12
  assign rsvd_ok_rda = ui1_zero_ok &&
                       !v[13] && !v[10] && !v[8] &&
                       v[9] && v[11] && v[12];
`else
  assign rsvd_ok_act = 1'b1;
  assign rsvd_ok_wra = 1'b1;
  assign rsvd_ok_rda = 1'b1;
  // Reserved bits carry no meaning in this build.
  logic rsvd_unused;
  assign rsvd_unused = &{u[13:11], u[7], v[13:12], 1'b0};
`endif

  logic is_act;
  logic is_wra;
  logic is_rda;
  logic is_legal;
  assign is_act   = op_act && rsvd_ok_act;
  assign is_wra   = op_wra && rsvd_ok_wra;
  assign is_rda   = op_rda && rsvd_ok_rda;
  assign is_legal = is_act || is_wra || is_rda;

  // Addressed bank and its current state
  logic [3:0] bank_idx;
  logic       bank_is_open;
  assign bank_idx     = {u[10:8], u[6]};
  assign bank_is_open = bank_open_q[bank_idx];

  // Opening an open bank, or auto-precharging a closed one, is a violation.
  logic bank_violation;
  assign bank_violation = (is_act && bank_is_open) ||
                          ((is_wra || is_rda) && !bank_is_open);

  logic legal_fire;
  assign legal_fire = decode_fire && is_legal;

  // ------------------------------------------------------------------
  // FSM and UI1 capture
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    ui1_next   = ui1_q;
    case (state)
      ST_IDLE: begin
        if (!bus.CS_n) begin
          ui1_next   = bus.CA;
          state_next = ST_UI2;
        end
      end
      ST_UI2: begin
        if (bus.CS_n) begin
          state_next = ST_IDLE;
        end else begin
          // Broken packet: restart framing with this CA as the new UI1.
          ui1_next   = bus.CA;
          state_next = ST_UI2;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Decoded outputs: non-zero only in the cycle after UI2
  // ------------------------------------------------------------------
  always_comb begin
    cmd_valid_next   = 1'b0;
    cmd_type_next    = CMD_NONE;
    bg_next          = 3'd0;
    ba_next          = 1'b0;
    row_next         = 16'd0;
    col_next         = 10'd0;
    err_frame_next   = frame_err;
    err_illegal_next = 1'b0;
    err_bank_next    = 1'b0;

    if (decode_fire) begin
      if (!is_legal) begin
        err_illegal_next = 1'b1;
      end else begin
        cmd_valid_next = 1'b1;
        bg_next        = u[10:8];
        ba_next        = u[6];
        err_bank_next  = bank_violation;
        if (is_act) begin
          cmd_type_next = CMD_ACT;
          row_next      = {v[11:0], u[5:2]};
        end else if (is_wra) begin
          cmd_type_next = CMD_WRA;
          col_next      = {v[7:1], 3'b000};
        end else begin
          cmd_type_next = CMD_RDA;
          col_next      = {v[7:0], 2'b00};
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Bank state: ACT sets the addressed bit, WRA/RDA clear it. A violating
  // command lands on a bit already in the target state, so set/clear
  // unconditionally gives "bit unchanged" for free.
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    always_comb begin
      bank_open_next[gi] = bank_open_q[gi];
      if (legal_fire && (bank_idx == 4'(gi))) begin
        bank_open_next[gi] = is_act;
      end
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ui1_q         <= 14'd0;
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= CMD_NONE;
      bg_q          <= 3'd0;
      ba_q          <= 1'b0;
      row_q         <= 16'd0;
      col_q         <= 10'd0;
      bank_open_q   <= 16'd0;
      err_frame_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      err_bank_q    <= 1'b0;
    end else begin
      state         <= state_next;
      ui1_q         <= ui1_next;
      cmd_valid_q   <= cmd_valid_next;
      cmd_type_q    <= cmd_type_next;
      bg_q          <= bg_next;
      ba_q          <= ba_next;
      row_q         <= row_next;
      col_q         <= col_next;
      bank_open_q   <= bank_open_next;
      err_frame_q   <= err_frame_next;
      err_illegal_q <= err_illegal_next;
      err_bank_q    <= err_bank_next;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_type    = cmd_type_q;
  assign bus.bg          = bg_q;
  assign bus.ba          = ba_q;
  assign bus.row         = row_q;
  assign bus.col         = col_q;
  assign bus.bank_open   = bank_open_q;
  assign bus.err_frame   = err_frame_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_bank    = err_bank_q;

endmodule

// File: doc/ca_cmd_decoder.md
# ca_cmd_decoder

Command/address receiver for the DDR5 CA bus: frames two-unit-interval (UI) command packets delimited by active-low chip select, decodes ACT, WRA and RDA into bank-group, bank, row and column fields, and tracks per-bank open/closed state. It sits on the device side of the CA/CS link (memory model and controller loopback checker), opposite the controller's packet generator. It reports malformed packets and bank-state protocol violations as one-cycle error pulses.

## Interface
- No parameters. The CA width (14), bank groups (8) and banks per group (2) are fixed.
- clk  in  1  sampling clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- CS_n  in  1  chip select; low marks UI1 of a packet.
- CA  in  14  command/address bus.
- cmd_valid  out  1  one-cycle pulse when a legal command is decoded.
- cmd_type  out  4  8=ACT, 5=WRA, 12=RDA, 0=none.
- bg  out  3  decoded bank group.
- ba  out  1  decoded bank.
- row  out  16  decoded row (ACT only, else 0).
- col  out  10  decoded column (WRA/RDA only, else 0).
- bank_open  out  16  open flag per bank, index {bg,ba}.
- err_frame  out  1  one-cycle pulse: framing error.
- err_illegal  out  1  one-cycle pulse: undecodable packet.
- err_bank  out  1  one-cycle pulse: bank-state violation.

## Operation
- FSM: IDLE, UI2.
- IDLE: CS_n=0 → latch CA into ui1_q → UI2. CS_n=1 → stay in IDLE.
- UI2: CS_n=1 → take CA as UI2, decode {ui1_q, CA} → IDLE.
- UI2: CS_n=0 → pulse err_frame, discard ui1_q, latch the new CA as UI1, stay in UI2.
- Decode of UI1 = u, UI2 = v:
  - ACT: u[1:0]=00. bg=u[10:8], ba=u[6], row={v[11:0],u[5:2]}.
  - WRA: u[1:0]=01, u[5:2]=0011. bg=u[10:8], ba=u[6], col={v[7:1],3'b000}.
  - RDA: u[1:0]=01, u[5:2]=0111. bg=u[10:8], ba=u[6], col={v[7:0],2'b00}.
  - Any other opcode → err_illegal, no cmd_valid.
- Bank tracking, bank index b={bg,ba}:
  - ACT with bank_open[b]=0 → set bank_open[b].
  - ACT with bank_open[b]=1 → err_bank, command still reported, bit stays set.
  - WRA/RDA with bank_open[b]=1 → clear bank_open[b] (auto-precharge).
  - WRA/RDA with bank_open[b]=0 → err_bank, command still reported, bit stays clear.
- An illegal packet never changes bank_open.
- err_frame and a decode in the same cycle are impossible by construction.
- err_illegal and err_bank are mutually exclusive.

## Timing
- Reset values: FSM=IDLE, cmd_valid=0, cmd_type=0, bg=0, ba=0, row=0, col=0, bank_open=0, all err=0.
- Reset asserted mid-packet aborts the packet with no pulses and returns to IDLE.
- Latency: for a packet whose UI1 is sampled at edge E0 and UI2 at E0+1, these are registered at E0+1 and valid for exactly one cycle:
  - cmd_valid, cmd_type, bg/ba/row/col
  - err_illegal/err_bank
  - the bank_open update
- cmd_type, bg, ba, row and col return to 0 the cycle after the pulse.
- Back-to-back packets are supported: CS_n=0 at E0+2 starts the next packet. Sustained rate is one command per 2 cycles.
- err_frame is registered at the edge sampling the offending CS_n=0 in UI2.

## Configuration
- CA_RSVD_CHECK_EN defined: a packet passing its opcode check is still illegal (err_illegal) unless all of these hold:
  - every field the encoder drives to fixed 0 is 0: u[13:11], u[7], and v bits 13:12 (ACT), 13,11:10,8 (WRA), 13,10,8 (RDA);
  - every VALID bit is 1: WRA v[0],v[9],v[12]; RDA v[9],v[11],v[12].
- CA_RSVD_CHECK_EN undefined: only opcode bits are checked and reserved/VALID bits are ignored.

## Test plan
- ACT: UI1=0x0574, UI2=0x0ABC → cmd_valid pulse, cmd_type=8, bg=5, ba=1, row=0xABCD, bank_open=0x0800.
- Then RDA: UI1=0x055D, UI2=0x1AA9 → cmd_type=12, col=0x2A4, bank_open=0x0000, no errors.
- WRA to a closed bank: UI1=0x054D, UI2=0x12AB → cmd_type=5, col=0x2A8, err_bank=1, bank_open stays 0.
- Two ACTs to bank 11 → first sets bank_open[11], second pulses err_bank, and bank_open[11] stays 1.
- CS_n low on two consecutive edges (CA=0x0574, then 0x055D), then UI2=0x1AA9 → err_frame at the second edge, then RDA decoded with no err_bank only if bank 11 is open.
- With CA_RSVD_CHECK_EN: RDA UI2=0x0AA9 (VALID bit 12 clear) → err_illegal, no cmd_valid. Without the macro → RDA decoded normally. Reset asserted between UI1 and UI2 → all outputs 0 and no pulse.
